// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider for the 32-bit integer divide: one quotient bit per cycle.
// Signed operation is built only when DIV_SIGNED_EN is defined; otherwise every divide is unsigned.
module div_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cancel,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [TAG_W-1:0] tag_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [TAG_W-1:0] tag_out
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [2:0] {StIdle, StPrep, StCalc, StFix, StDone} state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   a_q, b_q, dvsr_q;
  logic [TAG_W-1:0]   tag_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CntW-1:0]    cnt_q;

  // 33-bit partial remainder after the shift; the top bit is the bit shifted out of acc_q.
  logic [WIDTH:0]   part;
  logic [WIDTH-1:0] diff, low_sh, q_raw, r_raw;
  logic             ge;

  assign part   = acc_q[2*WIDTH-1:WIDTH-1];
  assign low_sh = {acc_q[WIDTH-2:0], 1'b0};
  assign ge     = part >= {1'b0, dvsr_q};
  // Only used when ge holds, so the result always fits in WIDTH bits.
  assign diff   = part[WIDTH-1:0] - dvsr_q;
  assign q_raw  = acc_q[WIDTH-1:0];
  assign r_raw  = acc_q[2*WIDTH-1:WIDTH];

  logic [WIDTH-1:0] a_abs, b_abs, q_out, r_out;

`ifdef DIV_SIGNED_EN
  logic sgn_q, qneg_q, rneg_q;
  logic a_neg, b_neg;

  assign a_neg = sgn_q & a_q[WIDTH-1];
  assign b_neg = sgn_q & b_q[WIDTH-1];
  assign a_abs = a_neg ? -a_q : a_q;
  assign b_abs = b_neg ? -b_q : b_q;
  assign q_out = qneg_q ? -q_raw : q_raw;
  assign r_out = rneg_q ? -r_raw : r_raw;
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;
  assign a_abs = a_q;
  assign b_abs = b_q;
  assign q_out = q_raw;
  assign r_out = r_raw;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      tag_out   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      dvsr_q    <= '0;
      tag_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
`ifdef DIV_SIGNED_EN
      sgn_q     <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          if (start && !cancel) begin
            a_q     <= dividend;
            b_q     <= divisor;
            tag_q   <= tag_in;
`ifdef DIV_SIGNED_EN
            sgn_q   <= is_signed;
`endif
            busy    <= 1'b1;
            state_q <= StPrep;
          end else begin
            state_q <= StIdle;
          end
        end
        StPrep: begin
          if (cancel) begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end else if (b_q == '0) begin
            quotient  <= '0;
            remainder <= '1;
            tag_out   <= tag_q;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_q   <= StDone;
          end else begin
            acc_q   <= {{WIDTH{1'b0}}, a_abs};
            dvsr_q  <= b_abs;
            cnt_q   <= CntW'(WIDTH - 1);
`ifdef DIV_SIGNED_EN
            qneg_q  <= a_neg ^ b_neg;
            rneg_q  <= a_neg;
`endif
            state_q <= StCalc;
          end
        end
        StCalc: begin
          if (cancel) begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end else begin
            acc_q <= ge ? {diff, low_sh[WIDTH-1:1], 1'b1} : {part[WIDTH-1:0], low_sh};
            cnt_q <= cnt_q - CntW'(1);
            if (cnt_q == '0) state_q <= StFix;
          end
        end
        StFix: begin
          busy <= 1'b0;
          if (cancel) begin
            state_q <= StIdle;
          end else begin
            quotient  <= q_out;
            remainder <= r_out;
            tag_out   <= tag_q;
            done      <= 1'b1;
            state_q   <= StDone;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: a reference model fills a scoreboard of expected
// results and completion cycles, and a monitor pops and compares on every done pulse.
module tb_div_sequencer;

`ifdef DIV_SIGNED_EN
  localparam bit SignedEn = 1'b1;
`else
  localparam bit SignedEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [4:0]  tag_in = '0;
  logic        busy, done;
  logic [31:0] quotient, remainder;
  logic [4:0]  tag_out;

  div_sequencer #(.WIDTH(32), .TAG_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cancel    (cancel),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .tag_in    (tag_in),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .tag_out   (tag_out)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic [4:0]  tag;
    int unsigned at;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_q = '0;
  logic [31:0] last_r = '0;
  logic [31:0] last_tag = '0;

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Independent reference: plain SV arithmetic plus the two defined corner cases.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                 input logic [4:0] tag);
    exp_t e;
    e.tag = tag;
    if (b == 32'd0) begin
      e.q  = 32'h0000_0000;
      e.r  = 32'hFFFF_FFFF;
      e.at = 2;
    end else begin
      e.at = 35;
      if (SignedEn && sgn) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.q = 32'h8000_0000;
          e.r = 32'h0;
        end else begin
          e.q = $signed(a) / $signed(b);
          e.r = $signed(a) % $signed(b);
        end
      end else begin
        e.q = a / b;
        e.r = a % b;
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("done_cycle", cyc, e.at);
        check_eq("quotient", quotient, e.q);
        check_eq("remainder", remainder, e.r);
        check_eq("tag_out", 32'(tag_out), 32'(e.tag));
        last_q   <= e.q;
        last_r   <= e.r;
        last_tag <= 32'(e.tag);
      end
    end
  end

  // Leaves the caller 1 time unit after the posedge that starts cycle c.
  task automatic wait_to(input int unsigned c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                       input logic [4:0] tag, input bit expect_done);
    exp_t e;
    e = model(a, b, sgn, tag);
    e.at += cyc;
    dividend  = a;
    divisor   = b;
    is_signed = sgn;
    tag_in    = tag;
    start     = 1'b1;
    if (expect_done) sb.push_back(e);
    wait_to(cyc + 1);
    start = 1'b0;
  endtask

  task automatic drain(input int unsigned budget);
    int unsigned n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("drain", 32'(sb.size()), 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string name);
    check_eq({name, "_busy"}, 32'(busy), 32'd0);
    check_eq({name, "_done"}, 32'(done), 32'd0);
    check_eq({name, "_q"}, quotient, 32'd0);
    check_eq({name, "_r"}, remainder, 32'd0);
    check_eq({name, "_tag"}, 32'(tag_out), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    wait_to(cyc + 1);
    rst_n = 1'b1;
    wait_to(cyc + 2);

    // 100 / 7 with a cycle-by-cycle busy window check.
    k = cyc;
    issue(32'd100, 32'd7, 1'b0, 5'd3, 1'b1);
    for (int i = 1; i <= 36; i++) begin
      @(negedge clk);
      check_eq("busy_window", 32'(busy), 32'((cyc - k >= 1) && (cyc - k <= 34)));
    end
    drain(60);

    issue(32'd5, 32'd0, 1'b0, 5'd7, 1'b1);
    drain(20);
    issue(32'd5, 32'd0, 1'b1, 5'd8, 1'b1);
    drain(20);
    issue(32'hFFFF_FFFF, 32'h10, 1'b0, 5'd11, 1'b1);
    drain(60);
    issue(32'hFFFF_FFF9, 32'd2, 1'b1, 5'd12, 1'b1);
    drain(60);
    issue(32'd7, 32'hFFFF_FFFE, 1'b1, 5'd13, 1'b1);
    drain(60);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 5'd14, 1'b1);
    drain(60);

    // Cancel mid-calculation; outputs must hold the previous result.
    k = cyc;
    issue(32'd1000, 32'd3, 1'b0, 5'd9, 1'b0);
    wait_to(k + 10);
    cancel = 1'b1;
    wait_to(k + 11);
    cancel = 1'b0;
    @(negedge clk);
    check_eq("cancel_busy", 32'(busy), 32'd0);
    check_eq("cancel_hold_q", quotient, last_q);
    check_eq("cancel_hold_r", remainder, last_r);
    check_eq("cancel_hold_tag", 32'(tag_out), last_tag);
    wait_to(k + 12);
    issue(32'd9, 32'd4, 1'b0, 5'd10, 1'b1);
    drain(60);

    // Start held high; operands while busy are a divide-by-zero that must be ignored.
    k = cyc;
    dividend = 32'd100; divisor = 32'd7; tag_in = 5'd1; is_signed = 1'b0; start = 1'b1;
    sb.push_back('{q: 32'd14, r: 32'd2, tag: 5'd1, at: k + 35});
    wait_to(k + 1);
    dividend = 32'd999; divisor = 32'd0; tag_in = 5'd31;
    wait_to(k + 35);
    dividend = 32'd50; divisor = 32'd5; tag_in = 5'd2;
    sb.push_back('{q: 32'd10, r: 32'd0, tag: 5'd2, at: k + 70});
    wait_to(k + 36);
    dividend = 32'd999; divisor = 32'd0; tag_in = 5'd31;
    wait_to(k + 70);
    start = 1'b0;
    drain(20);

    // Reset in the middle of an operation.
    k = cyc;
    issue(32'd1000, 32'd3, 1'b0, 5'd4, 1'b0);
    wait_to(k + 20);
    rst_n = 1'b0;
    wait_to(k + 21);
    @(negedge clk);
    check_zero_outputs("midreset");
    wait_to(k + 22);
    rst_n = 1'b1;
    wait_to(cyc + 1);
    issue(32'd123456, 32'd789, 1'b0, 5'd21, 1'b1);
    drain(60);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle sequencer for the CPU's 32-bit integer divide. It accepts a divide request from the EX stage and runs a restoring shift-subtract loop at one quotient bit per cycle. It returns quotient and remainder with a one-cycle `done` pulse for the HI/LO write-back path. It supports pipeline-flush cancellation and optional signed operation.

## Interface
- `WIDTH`, 32, operand/result width; the only supported value.
- `TAG_W`, 5, width of the opaque destination tag carried with the request.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `start`  in  1  request strobe; accepted only in IDLE or DONE.
- `cancel`  in  1  flush; aborts the operation in flight.
- `is_signed`  in  1  1 = signed divide, 0 = unsigned; sampled on accept.
- `dividend`  in  WIDTH  numerator; sampled on accept.
- `divisor`  in  WIDTH  denominator; sampled on accept.
- `tag_in`  in  TAG_W  sampled on accept.
- `busy`  out  1  high in PREP, CALC and FIX.
- `done`  out  1  one-cycle pulse in DONE.
- `quotient`  out  WIDTH  result; held until the next `done`.
- `remainder`  out  WIDTH  result; held until the next `done`.
- `tag_out`  out  TAG_W  tag of the finished operation; updates with the results.

## Operation
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE → PREP on `start` && !`cancel`. On accept, latch the operands, `is_signed` and `tag_in`.
- PREP:
  - If divisor == 0, go to DONE with quotient = 0x00000000 and remainder = 0xFFFFFFFF, regardless of sign.
  - Otherwise load the working register {32'b0, |dividend|}, load |divisor|, record the operand signs, set the iteration counter to 31, and go to CALC.
  - In unsigned mode, or with signed support compiled out, the operands are used as-is.
- CALC, per cycle:
  - Shift the 64-bit working register left by 1.
  - If the upper half ≥ divisor, subtract divisor from the upper half and set bit 0.
  - Decrement the counter; go to FIX after the iteration where the counter is 0, giving exactly 32 iterations.
- FIX:
  - Apply signs: quotient is negated if the dividend and divisor signs differ; remainder takes the dividend's sign (two's complement).
  - 0x80000000 / 0xFFFFFFFF signed gives quotient 0x80000000, remainder 0 (wraps; no trap).
  - Register `quotient`, `remainder` and `tag_out`, then go to DONE.
- DONE:
  - `done` = 1 for this cycle.
  - `start` && !`cancel` goes to PREP (back-to-back operation); otherwise go to IDLE.
- `cancel` in PREP, CALC or FIX: go to IDLE on the next edge. No `done` is produced and `quotient`/`remainder`/`tag_out` keep their previous values.
- `cancel` in DONE: `done` is still high that cycle, and the results are already visible. Any `start` in that cycle is ignored and the next state is IDLE.
- `cancel` together with `start` in IDLE: the start is ignored.
- `start` while `busy`: ignored. No queueing and no error.

## Timing
- Reset (`rst_n` = 0 at an edge) forces state = IDLE, `busy` = 0, `done` = 0, `quotient` = 0, `remainder` = 0, `tag_out` = 0, counter = 0.
- Reset mid-operation discards the operation with no `done`.
- Let cycle 0 be the cycle in which `start` is accepted:
  - Cycle 1: PREP.
  - Cycles 2–33: CALC.
  - Cycle 34: FIX.
  - Cycle 35: DONE, with `done` = 1 and the results valid.
  - `busy` is high in cycles 1–34.
- Divide-by-zero: PREP in cycle 1, DONE in cycle 2.
- Back-to-back: `start` in a DONE cycle places the next PREP in the following cycle, so throughput is one result per 35 cycles.
- Outputs are registered only; no combinational path from inputs to outputs.

## Configuration
- `DIV_SIGNED_EN` defined:
  - `is_signed` is honoured.
  - PREP takes absolute values and FIX applies sign correction.
- `DIV_SIGNED_EN` undefined:
  - `is_signed` is ignored and every operation is unsigned.
  - The negation logic is not built; FIX only registers the outputs.
  - Latency is unchanged at 35 cycles.

## Test plan
- Unsigned 100 / 7, tag 3:
  - `done` is high only in cycle 35 with quotient 14, remainder 2, `tag_out` 3.
  - `busy` is high for exactly cycles 1–34.
- Signed (`DIV_SIGNED_EN`):
  - −7 / 2 gives quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
  - 7 / −2 gives quotient 0xFFFFFFFD, remainder 1.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
- 5 / 0, in both signed and unsigned modes:
  - `done` in cycle 2 with quotient 0x00000000, remainder 0xFFFFFFFF.
- Cancel:
  - 1000 / 3 cancelled in cycle 10: `busy` low from cycle 11, no `done`, previous results unchanged.
  - A new `start` 9 / 4 in cycle 12 completes in cycle 47 with quotient 2, remainder 1.
- Back-to-back and ignored start:
  - `start` is held high throughout; a request 50 / 5 in its DONE cycle gives PREP next.
  - The second result is quotient 10, remainder 0, exactly 35 cycles after the first `done`.
  - A `start` asserted while `busy` has no effect.
- Reset mid-operation:
  - `rst_n` low in cycle 20 gives all outputs 0 and IDLE on the next edge, with no `done`.
  - The next request completes normally.
